// File: rtl/cdb_arbiter_mux.sv
// rtl/cdb_arbiter_mux.sv - N-channel round-robin registered multiplexer onto the common data bus
//
// Optional feature macro: CDB_ARB_STATS_EN (adds the stall_cnt output and its counter)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   per-channel result valid
//   in_data    channel i data in bits [i*DATA_W +: DATA_W]
//   in_tag     channel i tag in bits [i*TAG_W +: TAG_W]
//   in_ready   one-hot accept towards the granted channel
//   out_valid  output register holds a CDB entry
//   out_data   registered selected data
//   out_tag    registered selected tag
//   out_sel    index of the channel held in the output register
//   out_ready  downstream accepts the entry
//   stall_cnt  saturating count of cycles with out_valid & ~out_ready (CDB_ARB_STATS_EN only)

module cdb_arbiter_mux #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH*DATA_W-1:0]  in_data,
    input  logic [N_CH*TAG_W-1:0]   in_tag,
    output logic [N_CH-1:0]         in_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [TAG_W-1:0]        out_tag,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
`ifdef CDB_ARB_STATS_EN
   ,output logic [15:0]             stall_cnt
`endif
);

    logic                 out_valid_q, out_valid_d;
    logic [DATA_W-1:0]    out_data_q,  out_data_d;
    logic [TAG_W-1:0]     out_tag_q,   out_tag_d;
    logic [SEL_W-1:0]     out_sel_q,   out_sel_d;
    logic [SEL_W-1:0]     rr_ptr_q,    rr_ptr_d;

    logic                 load_en;
    logic                 any_req;
    logic [SEL_W-1:0]     grant;

    // The output register can take a new entry when it is empty or being drained this cycle.
    assign load_en = ~out_valid_q | out_ready;
    assign any_req = |in_valid;

    // Round-robin scan starting at rr_ptr; the index is wrapped explicitly so that
    // non-power-of-2 channel counts never address a channel beyond N_CH-1.
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            int               idx;
            logic [SEL_W-1:0] idx_s;
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            idx_s = SEL_W'(idx);
            if (!found && in_valid[idx_s]) begin
                grant = idx_s;
                found = 1'b1;
            end
        end
    end

    // Held low during reset so no producer sees an accept that the register will discard.
    always_comb begin
        in_ready = '0;
        if (rst_n && load_en && any_req) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_sel_d   = out_sel_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            if (any_req) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data[int'(grant)*DATA_W +: DATA_W];
                out_tag_d   = in_tag[int'(grant)*TAG_W +: TAG_W];
                out_sel_d   = grant;
                rr_ptr_d    = (grant == SEL_W'(N_CH - 1)) ? '0 : grant + 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_sel_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_sel_q   <= out_sel_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_sel   = out_sel_q;

`ifdef CDB_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter_mux.sv
// tb/tb_cdb_arbiter_mux.sv - directed self-checking bench for cdb_arbiter_mux

module tb_cdb_arbiter_mux;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    // 4-channel instance
    logic          rst_n;
    logic [3:0]    in_valid;
    logic [127:0]  in_data;
    logic [15:0]   in_tag;
    logic [3:0]    in_ready;
    logic          out_valid;
    logic [31:0]   out_data;
    logic [3:0]    out_tag;
    logic [1:0]    out_sel;
    logic          out_ready;
`ifdef CDB_ARB_STATS_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   stall_cnt3;
`endif

    // 3-channel instance for the wrap case
    logic          rst3_n;
    logic [2:0]    in3_valid;
    logic [95:0]   in3_data;
    logic [11:0]   in3_tag;
    logic [2:0]    in3_ready;
    logic          out3_valid;
    logic [31:0]   out3_data;
    logic [3:0]    out3_tag;
    logic [1:0]    out3_sel;
    logic          out3_ready;

    cdb_arbiter_mux #(.N_CH(4), .DATA_W(32), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_tag(in_tag),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
        .out_sel(out_sel), .out_ready(out_ready)
`ifdef CDB_ARB_STATS_EN
       ,.stall_cnt(stall_cnt)
`endif
    );

    cdb_arbiter_mux #(.N_CH(3), .DATA_W(32), .TAG_W(4)) dut3 (
        .clk(clk), .rst_n(rst3_n), .in_valid(in3_valid), .in_data(in3_data), .in_tag(in3_tag),
        .in_ready(in3_ready), .out_valid(out3_valid), .out_data(out3_data), .out_tag(out3_tag),
        .out_sel(out3_sel), .out_ready(out3_ready)
`ifdef CDB_ARB_STATS_EN
       ,.stall_cnt(stall_cnt3)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ch_data(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    function automatic logic [3:0] ch_tag(input int i);
        return 4'h8 + 4'(i);
    endfunction

    task automatic load_default_data();
        for (int i = 0; i < 4; i++) begin
            in_data[i*32 +: 32] = ch_data(i);
            in_tag[i*4 +: 4]    = ch_tag(i);
        end
    endtask

    initial begin
        logic [1:0] exp_sel;

        rst_n = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
        in_data = '0; in_tag = '0;
        load_default_data();
        rst3_n = 1'b0; in3_valid = '0; in3_data = '0; in3_tag = '0; out3_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in3_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
            in3_tag[i*4 +: 4]    = 4'(i + 1);
        end

        // 1: reset with all channels requesting
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd0);
            chk("rst_out_sel", 64'(out_sel), 64'd0);
            chk("rst_out_data", 64'(out_data), 64'd0);
        end
`ifdef CDB_ARB_STATS_EN
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_ch0", 64'(in_ready), 64'b0001);

        // 3: round robin with no bubbles
        for (int c = 0; c < 8; c++) begin
            tick();
            exp_sel = 2'(c % 4);
            chk("rr_out_valid", 64'(out_valid), 64'd1);
            chk("rr_out_sel", 64'(out_sel), 64'(exp_sel));
            chk("rr_out_data", 64'(out_data), 64'(ch_data(c % 4)));
            chk("rr_out_tag", 64'(out_tag), 64'(ch_tag(c % 4)));
        end

        // 2: single channel
        in_data[2*32 +: 32] = 32'hDEAD_BEEF;
        in_tag[2*4 +: 4]    = 4'h5;
        in_valid = 4'b0100;
        #1;
        chk("single_in_ready", 64'(in_ready), 64'b0100);
        tick();
        chk("single_out_valid", 64'(out_valid), 64'd1);
        chk("single_out_data", 64'(out_data), 64'hDEAD_BEEF);
        chk("single_out_tag", 64'(out_tag), 64'h5);
        chk("single_out_sel", 64'(out_sel), 64'd2);
        in_valid = 4'b0000;
        load_default_data();
        tick();
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("idle_out_sel_hold", 64'(out_sel), 64'd2);

        // 4: backpressure holding a ch1 entry
        in_valid = 4'b0010;
        tick();
        chk("bp_load_sel", 64'(out_sel), 64'd1);
        in_valid = 4'hF;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_sel", 64'(out_sel), 64'd1);
            chk("bp_out_data", 64'(out_data), 64'(ch_data(1)));
        end
`ifdef CDB_ARB_STATS_EN
        chk("bp_stall_cnt", 64'(stall_cnt), 64'd5);
`endif
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(in_ready), 64'b0100);
        tick();
        chk("bp_release_sel", 64'(out_sel), 64'd2);
        chk("bp_release_valid", 64'(out_valid), 64'd1);
`ifdef CDB_ARB_STATS_EN
        chk("bp_stall_cnt_hold", 64'(stall_cnt), 64'd5);
`endif

        // 6: reset mid-stall
        out_ready = 1'b0;
        tick();
`ifdef CDB_ARB_STATS_EN
        chk("stall_cnt_6", 64'(stall_cnt), 64'd6);
`endif
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_sel", 64'(out_sel), 64'd0);
`ifdef CDB_ARB_STATS_EN
        chk("midrst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("midrst_rr_ptr0", 64'(in_ready), 64'b0001);

        // 5: wrap with N_CH=3
        rst3_n = 1'b1;
        in3_valid = 3'b010;
        #1;
        chk("w3_first_ready", 64'(in3_ready), 64'b010);
        tick();
        chk("w3_first_sel", 64'(out3_sel), 64'd1);
        in3_valid = 3'b011;
        #1;
        chk("w3_ptr2_ready", 64'(in3_ready), 64'b001);
        tick();
        chk("w3_ptr2_sel", 64'(out3_sel), 64'd0);
        chk("w3_ptr2_data", 64'(out3_data), 64'hA000_0000);
        in3_valid = 3'b111;
        #1;
        chk("w3_ptr1_ready", 64'(in3_ready), 64'b010);
        in3_valid = 3'b100;
        #1;
        chk("w3_ch2_ready", 64'(in3_ready), 64'b100);
        tick();
        chk("w3_ch2_sel", 64'(out3_sel), 64'd2);
        chk("w3_ch2_tag", 64'(out3_tag), 64'd3);
        in3_valid = 3'b111;
        #1;
        chk("w3_wrap_ready", 64'(in3_ready), 64'b001);
        tick();
        chk("w3_wrap_sel", 64'(out3_sel), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
